// File: rtl/ahb_lite_esram.sv
// ahb_lite_esram: 64-bit AHB-Lite on-chip SRAM slave.
// Zero-wait reads and writes with byte lanes, read-after-write forwarding
// for back-to-back transfers, and a two-cycle ERROR response for illegal
// (oversized or misaligned) transfers. INIT_FILE names the preload image
// handed to the memory/FPGA build flow; an empty name leaves contents undefined.
module ahb_lite_esram #(
  parameter int MEM_AW    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [35:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [63:0] HWDATA,
  input  logic        HMASTLOCK,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [63:0] HRDATA
);

  // ERR1 stalls the bus (HREADY low); ERR2 completes the error and may
  // accept the next address phase, exactly like OKAY.
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [63:0] mem [2**MEM_AW];

  logic              accept;
  logic              a_legal;
  logic [7:0]        a_mask;
  logic [MEM_AW-1:0] a_index;
  logic              rd_en;
  logic              raw_hit;

  logic              wr_pend;   // legal write currently in its data phase
  logic              rd_phase;  // legal read currently in its data phase
  logic [MEM_AW-1:0] dp_index;
  logic [7:0]        dp_mask;
  logic [63:0]       rd_q;

  // Bus attributes with no effect on this slave; address bits above the
  // array alias.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HMASTLOCK, HADDR[35:MEM_AW+3]};

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [63:0] merge_lanes(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  mask);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  assign accept  = HSEL & HTRANS[1] & HREADY;
  assign a_index = HADDR[MEM_AW+2:3];
  assign rd_en   = accept & a_legal & ~HWRITE;
  assign raw_hit = wr_pend & (dp_index == a_index);

  // Address-phase decode: size/alignment legality and byte-lane mask.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    a_legal = 1'b0;
    a_mask  = 8'h00;
    case (HSIZE)
      3'd0: begin a_legal = 1'b1;                 a_mask = 8'h01; end
      3'd1: begin a_legal = (HADDR[0] == 1'b0);   a_mask = 8'h03; end
      3'd2: begin a_legal = (HADDR[1:0] == 2'b0); a_mask = 8'h0F; end
      3'd3: begin a_legal = (HADDR[2:0] == 3'b0); a_mask = 8'hFF; end
      default: ;
    endcase
    a_mask = a_mask << HADDR[2:0];
  end

  // Response state register.
  always_ff @(posedge HCLK) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (HRESET) state <= ST_OKAY;
    else        state <= state_nxt;
  end

  // Response next-state: an accepted illegal transfer starts the error pair.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OKAY, ST_ERR2: state_nxt = (accept && !a_legal) ? ST_ERR1 : ST_OKAY;
      ST_ERR1:          state_nxt = ST_ERR2;
      default:          state_nxt = ST_OKAY;
    endcase
  end

  assign HREADY = (state != ST_ERR1);
  assign HRESP  = (state != ST_OKAY) ? 2'b01 : 2'b00;
  assign HRDATA = rd_phase ? rd_q : 64'h0;

  // Data-phase control: what the next data phase does and where.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend  <= 1'b0;
      rd_phase <= 1'b0;
      dp_index <= '0;
      dp_mask  <= '0;
    end else begin
      wr_pend  <= accept & a_legal & HWRITE;
      rd_phase <= rd_en;
      if (accept) begin
        dp_index <= a_index;
        dp_mask  <= a_mask;
      end
    end
  end

  // RAM: byte-lane write at the end of a write data phase, synchronous read
  // at the address phase with the pending write's lanes forwarded.
  always_ff @(posedge HCLK) begin
    // NOTE: the array and its read register are deliberately not reset so
    // the memory maps onto plain SRAM; HRDATA is gated by rd_phase instead.
    if (wr_pend && !HRESET) begin
      for (int i = 0; i < 8; i++) begin
        if (dp_mask[i]) mem[dp_index][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
    if (rd_en) begin
      rd_q <= raw_hit ? merge_lanes(mem[a_index], HWDATA, dp_mask) : mem[a_index];
    end
  end

endmodule

// File: tb/tb_ahb_lite_esram.sv
// tb_ahb_lite_esram: randomized self-checking bench for ahb_lite_esram.
// A byte-addressed reference memory and a transfer-level bus model predict
// HREADY/HRESP/HRDATA for every cycle.
module tb_ahb_lite_esram;

  localparam int          MEM_AW = 14;
  localparam logic [35:0] BASE   = 36'h0_2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [35:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [63:0] hwdata;
  logic        hmastlock;
  logic        hready;
  logic [1:0]  hresp;
  logic [63:0] hrdata;

  always #5 clk = ~clk;

  ahb_lite_esram #(.MEM_AW(MEM_AW)) dut (
    .HCLK      (clk),
    .HRESET    (rst),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HWRITE    (hwrite),
    .HTRANS    (htrans),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HWDATA    (hwdata),
    .HMASTLOCK (hmastlock),
    .HREADY    (hready),
    .HRESP     (hresp),
    .HRDATA    (hrdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [35:0] addr;
    logic [63:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [7:0]  mdl [int];   // reference memory, keyed by aliased byte offset
  logic [63:0] last_rd;

  function automatic int offset_of(input logic [35:0] a);
    return int'(a[MEM_AW+2:0]);
  endfunction

  // Legal when the size is at most a dword and the address is size-aligned.
  function automatic bit is_legal(input xfer_t t);
    int nbytes;
    if (t.size > 3'd3) return 1'b0;
    nbytes = 1 << t.size;
    return (offset_of(t.addr) % nbytes) == 0;
  endfunction

  function automatic void model_write(input xfer_t t);
    int nbytes, a;
    nbytes = 1 << t.size;
    for (int i = 0; i < nbytes; i++) begin
      a = offset_of(t.addr) + i;
      mdl[a] = t.wdata[8*(a % 8) +: 8];
    end
  endfunction

  function automatic void model_read(input logic [35:0] addr, output logic [63:0] word,
                                     output bit known);
    int base;
    base  = offset_of(addr) - (offset_of(addr) % 8);
    word  = 64'h0;
    known = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (mdl.exists(base + i)) word[8*i +: 8] = mdl[base + i];
      else known = 1'b0;
    end
  endfunction

  task automatic push(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [35:0] addr, input logic [63:0] wdata);
    xfer_t t;
    t.sel = sel; t.trans = trans; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    q.push_back(t);
  endtask

  // Drive queued transfers as a pipelined master and check every cycle.
  task automatic run_queue();
    xfer_t       cur, dp;
    bit          cur_v, dp_v, exp_ready, rd_known;
    int          err_phase;
    logic [1:0]  exp_resp;
    logic [63:0] exp_rdata;
    dp_v      = 1'b0;
    err_phase = 0;
    cur_v     = (q.size() > 0);
    if (cur_v) cur = q.pop_front();
    while (cur_v || dp_v) begin
      @(posedge clk); #1;
      if (cur_v) begin
        hsel = cur.sel; htrans = cur.trans; hwrite = cur.wr; hsize = cur.size; haddr = cur.addr;
      end else begin
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
      end
      hburst    = 3'($urandom);
      hmastlock = 1'($urandom);
      hwdata    = dp_v ? dp.wdata : {$urandom, $urandom};

      exp_ready = 1'b1;
      exp_resp  = 2'b00;
      exp_rdata = 64'h0;
      rd_known  = 1'b1;
      if (dp_v && !is_legal(dp)) begin
        exp_resp  = 2'b01;
        exp_ready = (err_phase != 1);
      end else if (dp_v && !dp.wr) begin
        model_read(dp.addr, exp_rdata, rd_known);
      end

      @(negedge clk);
      check("hready", 64'(hready), 64'(exp_ready));
      check("hresp", 64'(hresp), 64'(exp_resp));
      if (rd_known) check("hrdata", hrdata, exp_rdata);
      if (dp_v && !dp.wr && is_legal(dp)) last_rd = hrdata;

      if (exp_ready) begin
        if (dp_v && dp.wr && is_legal(dp)) model_write(dp);
        dp_v      = cur_v && cur.sel && cur.trans[1];
        dp        = cur;
        err_phase = (dp_v && !is_legal(dp)) ? 1 : 0;
        cur_v     = (q.size() > 0);
        if (cur_v) cur = q.pop_front();
      end else begin
        err_phase = 2;
      end
    end
  endtask

  initial begin
    int off;
    xfer_t t;
    rst = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
    hsize = 3'd0; hburst = 3'd0; hwdata = '0; hmastlock = 1'b0;
    last_rd = '0;

    // Reset for two cycles with the bus idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hready", 64'(hready), 64'd1);
    check("rst_hresp", 64'(hresp), 64'd0);
    check("rst_hrdata", hrdata, 64'h0);
    rst = 1'b0;

    // Prefill the 512-byte test window so every read is predictable.
    for (int i = 0; i < 64; i++) push(1'b1, 2'b10, 1'b1, 3'd3, BASE + 36'(8*i), {$urandom, $urandom});
    run_queue();

    // Dword write then read.
    push(1'b1, 2'b10, 1'b1, 3'd3, BASE + 36'h10, 64'h0123_4567_89AB_CDEF);
    push(1'b1, 2'b10, 1'b0, 3'd3, BASE + 36'h10, 64'h0);
    run_queue();
    check("dword_rd", last_rd, 64'h0123_4567_89AB_CDEF);

    // Byte and half lanes merged into the dword.
    push(1'b1, 2'b10, 1'b1, 3'd0, BASE + 36'h13, 64'h5A << 24);
    push(1'b1, 2'b11, 1'b1, 3'd1, BASE + 36'h16, 64'hBEEF << 48);
    push(1'b1, 2'b11, 1'b0, 3'd3, BASE + 36'h10, 64'h0);
    run_queue();
    check("lanes_rd", last_rd, 64'hBEEF_4567_5AAB_CDEF);

    // Pipelined read-after-write to the same dword.
    push(1'b1, 2'b10, 1'b1, 3'd2, BASE + 36'h104, {32'hDEAD_BEEF, 32'h0});
    push(1'b1, 2'b10, 1'b0, 3'd3, BASE + 36'h100, 64'h0);
    run_queue();
    check("raw_hi", 64'(last_rd[63:32]), 64'h0000_0000_DEAD_BEEF);

    // Misaligned word read, oversized write, then readback of the target.
    push(1'b1, 2'b10, 1'b0, 3'd2, BASE + 36'h02, 64'h0);
    push(1'b1, 2'b10, 1'b1, 3'd4, BASE + 36'h08, 64'h1111);
    push(1'b1, 2'b10, 1'b0, 3'd3, BASE + 36'h08, 64'h0);
    run_queue();

    // BUSY and unselected writes leave memory alone.
    push(1'b1, 2'b01, 1'b1, 3'd3, BASE + 36'h10, {$urandom, $urandom});
    push(1'b0, 2'b10, 1'b1, 3'd3, BASE + 36'h10, {$urandom, $urandom});
    push(1'b1, 2'b10, 1'b0, 3'd3, BASE + 36'h10, 64'h0);
    run_queue();
    check("idle_keep", last_rd, 64'hBEEF_4567_5AAB_CDEF);

    // Random traffic with aliased upper address bits.
    for (int n = 0; n < 400; n++) begin
      t.sel   = ($urandom_range(0, 9) != 0);
      t.trans = ($urandom_range(0, 9) < 7) ? {1'b1, 1'($urandom)} : 2'($urandom_range(0, 1));
      t.wr    = 1'($urandom);
      t.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      off     = int'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) off = off - (off % 8);
      t.addr  = (36'($urandom) << (MEM_AW + 3)) | 36'(off);
      t.wdata = {$urandom, $urandom};
      q.push_back(t);
    end
    run_queue();

    // Final sweep of the window.
    for (int i = 0; i < 64; i++) push(1'b1, 2'b11, 1'b0, 3'd3, BASE + 36'(8*i), 64'h0);
    run_queue();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
